mul: RTL and testbench



---
 rtl/mini_pkg.sv | 13 +
 rtl/mul_add.sv | 14 +
 rtl/mul.sv | 101 ++++++++++
 tb/tb_mul.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mini_pkg.sv
// Shared types and constants for the mini-computer ALU multi-cycle units.
package mini_pkg;

  localparam int MINI_N = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

  // Bits needed to count 0..N for an N-step sequencer.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mul_add.sv
// Combinational W-bit adder with carry in/out; addition counterpart of sub.
module add #(
  parameter int W = 16
) (
  input  logic [W-1:0] in,
  input  logic [W-1:0] num,
  input  logic         cin,
  output logic [W-1:0] answer,
  output logic         cout
);

  assign {cout, answer} = {1'b0, in} + {1'b0, num} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mul.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per clock.
// Define MUL_EARLY_EXIT_EN to end RUN once the remaining multiplier bits are zero.
module mul
  import mini_pkg::*;
#(
  parameter int N = MINI_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic           overflow
);

  localparam int            CW   = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mul_state_t     state;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;

  logic [2*N-1:0] sum;
  logic [2*N-1:0] acc_nxt;
  logic           last;
  logic           add_unused_cout;

  add #(.W(2*N)) u_add (
    .in     (acc),
    .num    (mcand),
    .cin    (1'b0),
    .answer (sum),
    .cout   (add_unused_cout)
  );

  assign acc_nxt = mplier[0] ? sum : acc;

`ifdef MUL_EARLY_EXIT_EN
  // Remaining multiplier bits all zero: further steps would add nothing.
  assign last = (cnt == LAST) || (mplier[N-1:1] == '0);
`else
  assign last = (cnt == LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            // Publish the post-edge accumulator so product lands with done.
            product  <= acc_nxt;
            overflow <= |acc_nxt[2*N-1:N];
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul.sv
// Directed bench for mul with a scoreboard queue of expected results.
module tb_mul;

  localparam int N = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
  logic           overflow;

  typedef struct {
    logic [2*N-1:0] p;
    logic           ov;
    int             lat;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  mul #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // Cycles from the start-presenting cycle to the done cycle.
  function automatic int exp_lat(input logic [N-1:0] bb);
`ifdef MUL_EARLY_EXIT_EN
    int hi;
    hi = 0;
    for (int i = 0; i < N; i++) if (bb[i]) hi = i;
    return hi + 2;
`else
    return N + 1;
`endif
  endfunction

  task automatic push_exp(input logic [N-1:0] aa, input logic [N-1:0] bb);
    exp_t e;
    logic [2*N-1:0] p;
    p     = {{N{1'b0}}, aa} * {{N{1'b0}}, bb};
    e.p   = p;
    e.ov  = (p >= (1 << N));
    e.lat = exp_lat(bb);
    q.push_back(e);
  endtask

  // One operation; optionally re-presents start with other operands during RUN.
  task automatic do_op(input string tag, input logic [N-1:0] aa, input logic [N-1:0] bb,
                       input bit interfere);
    int   lat;
    int   bc;
    exp_t e;
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    push_exp(aa, bb);
    @(posedge clk); #1;
    lat = 1;
    bc  = busy ? 1 : 0;
    if (interfere) begin a = 8'd9; b = 8'd9; end
    else start = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bc++;
      if (interfere && lat == 3) start = 1'b0;
    end
    e = q.pop_front();
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_product"}, {16'd0, product}, {16'd0, e.p});
    chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, e.ov});
    chk({tag, "_busy_cycles"}, bc, lat);
    @(posedge clk); #1;
    chk({tag, "_done_strobe"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    do_op("m13x11", 8'd13, 8'd11, 1'b0);
    do_op("m255x255", 8'd255, 8'd255, 1'b0);
    do_op("m200x0", 8'd200, 8'd0, 1'b0);
    do_op("m7x3_ign", 8'd7, 8'd3, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    chk("hold_product", {16'd0, product}, 32'd21);
    chk("hold_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of RUN.
    @(negedge clk);
    a = 8'd100; b = 8'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrun_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_product", {16'd0, product}, 32'd0);
    chk("arst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    do_op("m2x3", 8'd2, 8'd3, 1'b0);
    do_op("m50x1", 8'd50, 8'd1, 1'b0);
    do_op("m1x128", 8'd1, 8'd128, 1'b0);
    do_op("m16x17", 8'd16, 8'd17, 1'b0);

    // Held start is taken again on the first IDLE cycle after done.
    @(negedge clk);
    a = 8'd3; b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    begin
      int k;
      k = 0;
      while (!done && k < 40) begin @(posedge clk); #1; k++; end
    end
    chk("held_first_product", {16'd0, product}, 32'd15);
    @(posedge clk); #1;
    chk("held_idle_gap", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("held_reaccept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    repeat (12) @(posedge clk);

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
